// File: rtl/discriminator_counter_axil_slave_if.sv
// AXI4-Lite bundle for the discriminator counter register block.
// Signal names follow the s00_axi_* bus naming.
interface discriminator_counter_axil_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0]   s00_axi_awaddr;
  logic [2:0]          s00_axi_awprot;
  logic                s00_axi_awvalid;
  logic                s00_axi_awready;
  logic [DATA_W-1:0]   s00_axi_wdata;
  logic [DATA_W/8-1:0] s00_axi_wstrb;
  logic                s00_axi_wvalid;
  logic                s00_axi_wready;
  logic [1:0]          s00_axi_bresp;
  logic                s00_axi_bvalid;
  logic                s00_axi_bready;
  logic [ADDR_W-1:0]   s00_axi_araddr;
  logic [2:0]          s00_axi_arprot;
  logic                s00_axi_arvalid;
  logic                s00_axi_arready;
  logic [DATA_W-1:0]   s00_axi_rdata;
  logic [1:0]          s00_axi_rresp;
  logic                s00_axi_rvalid;
  logic                s00_axi_rready;

  modport slave (
    input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    input  s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    input  s00_axi_rready,
    output s00_axi_awready, s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
  );

  modport master (
    output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    output s00_axi_rready,
    input  s00_axi_awready, s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
  );
endinterface

// File: rtl/discriminator_counter_axil_slave.sv
// AXI4-Lite register block that counts synchronized rising edges of disc_in
// and raises a level interrupt once COUNT reaches a non-zero THRESH.
module discriminator_counter_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  discriminator_counter_axil_slave_if.slave s_axi,
  input  logic                              disc_in,
  output logic                              count_irq
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [DW-1:0] CLR_BIT     = DW'(2);

  logic                   r_aw_full, r_w_full;
  logic [1:0]             r_aw_sel;
  logic [DW-1:0]          r_wdata;
  logic [NB-1:0]          r_wstrb;
  logic                   r_bvalid;
  logic [1:0]             r_bresp;
  logic                   r_rvalid;
  logic [DW-1:0]          r_rdata;
  logic [DW-1:0]          r_ctrl, r_thresh, r_count, r_scratch;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;
  logic                   r_irq;

  logic                   w_update, w_rise, w_clr, w_ar_fire;
  logic [DW-1:0]          w_bytemask, w_wr_old, w_merged, w_rd_mux, w_count_next;
  logic                   w_unused;

  assign s_axi.s00_axi_awready = s_axi.s00_axi_awvalid & ~r_aw_full & ~r_bvalid;
  assign s_axi.s00_axi_wready  = s_axi.s00_axi_wvalid & ~r_w_full & ~r_bvalid;
  assign s_axi.s00_axi_arready = s_axi.s00_axi_arvalid & ~r_rvalid;
  assign s_axi.s00_axi_bvalid  = r_bvalid;
  assign s_axi.s00_axi_bresp   = r_bresp;
  assign s_axi.s00_axi_rvalid  = r_rvalid;
  assign s_axi.s00_axi_rdata   = r_rdata;
  assign s_axi.s00_axi_rresp   = RESP_OKAY;
  assign count_irq             = r_irq;

  assign w_unused  = ^{s_axi.s00_axi_awprot, s_axi.s00_axi_arprot,
                       s_axi.s00_axi_awaddr[1:0], s_axi.s00_axi_araddr[1:0]};
  assign w_ar_fire = s_axi.s00_axi_arready;
  assign w_update  = r_aw_full & r_w_full;
  assign w_rise    = r_sync[SYNC_STAGES-1] & ~r_edge;
  assign w_clr     = w_update && (r_aw_sel == 2'd0) && r_wstrb[0] && r_wdata[1];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_mask
      assign w_bytemask[gi*8 +: 8] = {8{r_wstrb[gi]}};
    end
  endgenerate

  always_comb begin
    w_wr_old = '0;
    case (r_aw_sel)
      2'd0:    w_wr_old = r_ctrl;
      2'd1:    w_wr_old = r_thresh;
      2'd3:    w_wr_old = r_scratch;
      default: w_wr_old = '0;
    endcase
    w_merged = (w_wr_old & ~w_bytemask) | (r_wdata & w_bytemask);
  end

  always_comb begin
    w_rd_mux = '0;
    case (s_axi.s00_axi_araddr[3:2])
      2'd0:    w_rd_mux = r_ctrl;
      2'd1:    w_rd_mux = r_thresh;
      2'd2:    w_rd_mux = r_count;
      default: w_rd_mux = r_scratch;
    endcase
  end

  // Clear has priority over a coincident edge; the counter sticks at all-ones.
  always_comb begin
    w_count_next = r_count;
    if (w_clr) begin
      w_count_next = '0;
    end else if (r_ctrl[0] && w_rise && (r_count != '1)) begin
      w_count_next = r_count + 1'b1;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], disc_in};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_aw_sel  <= 2'd0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_ctrl    <= '0;
      r_thresh  <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (s_axi.s00_axi_awready) begin
        r_aw_full <= 1'b1;
        r_aw_sel  <= s_axi.s00_axi_awaddr[3:2];
      end
      if (s_axi.s00_axi_wready) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_axi.s00_axi_wdata;
        r_wstrb  <= s_axi.s00_axi_wstrb;
      end
      if (w_update) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= (r_aw_sel == 2'd2) ? RESP_SLVERR : RESP_OKAY;
        case (r_aw_sel)
          2'd0:    r_ctrl    <= w_merged & ~CLR_BIT;
          2'd1:    r_thresh  <= w_merged;
          2'd3:    r_scratch <= w_merged;
          default: ;
        endcase
      end else if (r_bvalid && s_axi.s00_axi_bready) begin
        r_bvalid <= 1'b0;
      end
      r_count <= w_count_next;
      r_irq   <= (r_thresh != '0) && (r_count >= r_thresh);
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_ar_fire) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_mux;
    end else if (r_rvalid && s_axi.s00_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end
endmodule

// File: doc/discriminator_counter_axil_slave.md
Name: discriminator_counter_axil_slave

Overview:
AXI4-Lite responder for the discriminator counter IP. It serves the bus master: it accepts writes and reads over four 32-bit registers. It counts rising edges of an asynchronous discriminator pulse input and raises a level interrupt when the count reaches a programmable threshold. It sits between the AXI interconnect (the master VIP in simulation) and the analog-discriminator front end.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register and bits [1:0] are ignored.
SYNC_STAGES, 2, flops in the disc_in synchronizer; minimum 2.

Ports:
s00_axi_aclk  in  1  single clock for everything.
s00_axi_areset  in  1  synchronous, active-high reset.
s00_axi_awaddr  in  4  write address.
s00_axi_awprot  in  3  ignored.
s00_axi_awvalid / s00_axi_awready  in / out  1  write address handshake.
s00_axi_wdata  in  32  write data.
s00_axi_wstrb  in  4  byte enables.
s00_axi_wvalid / s00_axi_wready  in / out  1  write data handshake.
s00_axi_bresp  out  2  write response.
s00_axi_bvalid / s00_axi_bready  out / in  1  write response handshake.
s00_axi_araddr  in  4  read address.
s00_axi_arprot  in  3  ignored.
s00_axi_arvalid / s00_axi_arready  in / out  1  read address handshake.
s00_axi_rdata  out  32  read data.
s00_axi_rresp  out  2  read response.
s00_axi_rvalid / s00_axi_rready  out / in  1  read data handshake.
disc_in  in  1  asynchronous discriminator pulse.
count_irq  out  1  level interrupt.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset values: all ready/valid outputs 0; bresp=rresp=0; rdata=0; count_irq=0; all registers 0; synchronizer and edge flops 0.
- Register map:
  - 0x0 CTRL (RW): bit0 EN, bit1 CLR (self-clearing; reads 0); other bits are stored but have no function.
  - 0x4 THRESH (RW).
  - 0x8 COUNT (RO).
  - 0xC SCRATCH (RW).
- Write channel:
  - AW and W are latched independently; each ready asserts for 1 cycle when its holding slot is empty and bvalid=0.
  - The register update happens in the cycle after both are held. WSTRB is honoured per byte.
  - bvalid asserts in that same update cycle and holds until bready; AW/W are not accepted while bvalid=1.
  - bresp=OKAY (00) except a write to COUNT: SLVERR (10), data discarded.
- Read channel:
  - arready pulses for 1 cycle when arvalid=1 and rvalid=0.
  - rdata is registered in the handshake cycle; rvalid asserts the next cycle (1-cycle latency) and holds with stable rdata until rready.
  - rresp always OKAY.
- Concurrency: reads and writes proceed concurrently. A read of a register in the cycle it is written returns the old value.
- Counter:
  - disc_in passes through SYNC_STAGES flops plus one edge flop.
  - A rising edge while EN=1 increments COUNT by 1.
  - COUNT saturates at 0xFFFFFFFF; no wrap.
  - A CLR write zeroes COUNT in the update cycle. Clear wins over a coincident increment.
- Interrupt: count_irq is registered; it equals (THRESH!=0) && (COUNT>=THRESH), evaluated on the registered values, so it lags a COUNT/THRESH change by 1 cycle. Clearing COUNT or writing a larger THRESH deasserts it.
- Reset mid-transaction: a pending B or R is dropped, valid goes to 0, and all held AW/W are discarded.

Test Plan:
1. Write 0x1,0x2,0x3,0x4 to 0x0..0xC, then read back. Expect reads 0x1 (CTRL, CLR bit reads 0), 0x2, 0x0 (COUNT), 0x4. Expect bresp OKAY for 0x0/0x4/0xC and SLVERR for 0x8.
2. W before AW with 3 idle cycles between them, and bready held low 5 cycles. Expect a single update after AW, bvalid held 5 cycles, and no second acceptance while bvalid=1.
3. EN=1, THRESH=5, 5 disc_in pulses of 3 cycles each. Expect COUNT=5 and count_irq=1 within SYNC_STAGES+3 cycles of the last edge. Then write CTRL=0x3: expect COUNT=0 and count_irq=0 one cycle later.
4. EN=0 with 4 pulses: COUNT stays 0. Then a CLR write coincident with a synchronized edge: COUNT=0.
5. Force COUNT to 0xFFFFFFFE (via backdoor), then 3 pulses. Expect COUNT=0xFFFFFFFF with no wrap.
6. Write 0xAABBCCDD to SCRATCH with wstrb=0b0101 over 0. Expect a read of 0x00BB00DD. Assert reset while rvalid=1: rvalid=0 next cycle and SCRATCH=0.
